// File: rtl/data_ram_pkg.sv
// Shared constants and helpers for the byte-strobed data memory.
package data_ram_pkg;

   localparam int WORD_W = 32;
   localparam int LANES  = 4;
   localparam int BYTE_W = 8;

   // Number of word-index bits needed to address a memory of the given depth.
   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte column of the data memory: DEPTH x 8 storage, single write port,
// combinational read, whole column cleared by asynchronous reset.
module data_ram_lane #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] index,
   input  logic [7:0]       din,
   output logic [7:0]       dout
);

   logic [7:0] mem [DEPTH];

   // Byte storage: reset clears every entry, otherwise write the strobed byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[index] <= din;
      end
   end

   // Read port: addressed byte, no bypass of a write pending this cycle.
   always_comb begin
      dout = mem[index];
   end

endmodule

// File: rtl/data_ram.sv
// Word-organised data memory with per-byte write strobes for the RV32 core.
// Loads are combinational; stores land on the rising edge of clk.
// Optional macro DATA_RAM_BOUNDS_CHECK_EN: addresses with any bit set above the
// word index drop the write and read as zero instead of wrapping.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [3:0]        mem_wmask,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out
);

   localparam int IDX_W = idx_width(DEPTH);

   logic [IDX_W-1:0]  index;
   logic              oob;
   logic [WORD_W-1:0] lane_data;
   logic              unused_addr_bits;

   assign index = address[IDX_W+1:2];

   // Byte offset never selects lanes; upper bits only matter for bounds checking.
   assign unused_addr_bits = ^{address[ADDR_W-1:IDX_W+2], address[1:0]};

`ifdef DATA_RAM_BOUNDS_CHECK_EN
   // Out-of-range when any bit above the word index is set.
   always_comb begin
      oob = |address[ADDR_W-1:IDX_W+2];
   end
`else
   // Upper bits ignored: the address wraps modulo DEPTH words.
   always_comb begin
      oob = 1'b0;
   end
`endif

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      data_ram_lane #(
         .DEPTH (DEPTH),
         .IDX_W (IDX_W)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .we    (we & mem_wmask[g] & ~oob),
         .index (index),
         .din   (data_in[g*BYTE_W +: BYTE_W]),
         .dout  (lane_data[g*BYTE_W +: BYTE_W])
      );
   end

   // Output word: concatenated lanes, forced to zero for out-of-range addresses.
   always_comb begin
      data_out = oob ? '0 : lane_data;
   end

endmodule

// File: tb/tb_data_ram.sv
`timescale 1ns/100ps
module tb_data_ram;

   localparam int DEPTH = 64;

   logic        clk;
   logic        rst;
   logic        we;
   logic [3:0]  mem_wmask;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;

   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];
   int          total;
   int          passed;

   data_ram #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .mem_wmask (mem_wmask),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #1 clk = ~clk;

   function automatic logic addr_oob(input logic [31:0] a);
`ifdef DATA_RAM_BOUNDS_CHECK_EN
      return |a[31:8];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (rst || addr_oob(a)) return 32'h0;
      return model[a[7:2]];
   endfunction

   task automatic model_write(input logic w, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] d);
      logic [31:0] word;
      if (!w || rst || addr_oob(a)) return;
      word = model[a[7:2]];
      for (int i = 0; i < 4; i++) begin
         if (m[i]) word[8*i +: 8] = d[8*i +: 8];
      end
      model[a[7:2]] = word;
   endtask

   task automatic expect_word(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag);
      logic [31:0] e;
      e = exp_q.pop_front();
      total++;
      assert (data_out === e) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, data_out, e);
   endtask

   // One clock step: checks the pre-edge value (old contents) and post-edge value.
   task automatic step(input string tag, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
      @(negedge clk);
      we = w; address = a; mem_wmask = m; data_in = d;
      #0.5;
      expect_word(model_read(a));
      check({tag, "_pre"});
      @(posedge clk);
      model_write(w, a, m, d);
      #0.5;
      expect_word(model_read(a));
      check({tag, "_post"});
   endtask

   initial begin
      total = 0;
      passed = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      rst = 1'b1; we = 1'b0; mem_wmask = 4'h0; address = '0; data_in = '0;

      // Reset held for two cycles, with a write attempt that must be lost.
      step("rst_wr0", 1'b1, 32'd0,  4'hF, 32'hDEADBEEF);
      step("rst_rd4", 1'b0, 32'd4,  4'hF, 32'h0);
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
      step("rd0_after_rst",  1'b0, 32'd0,  4'hF, 32'h0);
      step("rd8_after_rst",  1'b0, 32'd8,  4'hF, 32'h0);
      step("rd12_after_rst", 1'b0, 32'd12, 4'hF, 32'h0);

      // Full and partial writes.
      step("w0_full",  1'b1, 32'd0,  4'b1111, 32'h12345678);
      step("w1_lane0", 1'b1, 32'd1,  4'b0001, 32'h12345678);
      step("w2_lane0", 1'b1, 32'd2,  4'b0001, 32'h12345678);
      step("w4_m0011", 1'b1, 32'd4,  4'b0011, 32'h12345678);
      step("w5_m0110", 1'b1, 32'd5,  4'b0110, 32'h12345678);
      step("w12_full", 1'b1, 32'd12, 4'b1111, 32'h12345678);

      // Readback with fixed constants as well as the model.
      step("rb0",  1'b0, 32'd0,  4'h0, 32'h0);
      expect_word(32'h12345678); check("rb0_const");
      step("rb4",  1'b0, 32'd4,  4'h0, 32'h0);
      expect_word(32'h00345678); check("rb4_const");
      step("rb8",  1'b0, 32'd8,  4'h0, 32'h0);
      expect_word(32'h00000000); check("rb8_const");
      step("rb12", 1'b0, 32'd12, 4'h0, 32'h0);
      expect_word(32'h12345678); check("rb12_const");

      // Empty mask and write-disabled cases leave memory untouched.
      step("we_mask0", 1'b1, 32'd0, 4'b0000, 32'hFFFFFFFF);
      step("we0_mask", 1'b0, 32'd0, 4'b1111, 32'hFFFFFFFF);
      expect_word(32'h12345678); check("word0_kept");

      // Upper address bits: wrap, or drop under bounds checking.
      step("wrap_wr", 1'b1, 32'd4*DEPTH, 4'b1111, 32'hA5A5A5A5);
      step("wrap_rd0", 1'b0, 32'd0, 4'h0, 32'h0);
`ifdef DATA_RAM_BOUNDS_CHECK_EN
      expect_word(32'h12345678); check("wrap_word0_const");
      step("oob_rd", 1'b0, 32'd4*DEPTH, 4'h0, 32'h0);
      expect_word(32'h0); check("oob_rd_const");
`else
      expect_word(32'hA5A5A5A5); check("wrap_word0_const");
`endif
      step("w_hi", 1'b1, 32'd4*(DEPTH-1) + 32'd3, 4'b1001, 32'hCAFEF00D);
      expect_word(32'hCA00000D); check("w_hi_const");

      // Asynchronous reset between edges clears contents immediately.
      @(posedge clk);
      we = 1'b0; address = 32'd12;
      #0.3;
      rst = 1'b1;
      #0.1;
      expect_word(32'h0); check("async_rst_now");
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      #0.2;
      for (int i = 0; i < DEPTH; i++) begin
         address = i * 4;
         #0.1;
         expect_word(32'h0);
         check("clear_all");
      end
      step("post_rst_wr", 1'b1, 32'd8, 4'b1111, 32'h0BADC0DE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
